bus_xfer_ctrl: RTL and testbench

- Initiator side of the 4-bit internal bus read-select/write-select protocol.
- Takes a transfer request naming one source and one destination. Sequences one-hot read-select strobes (the source drives the bus) and write-select strobes (the destination latches the bus) with a fixed setup/write/release timing.
- Sits between the microcode decoder and the register operand blocks. It guarantees that no transfer asserts a write strobe without a stable driven bus.

---
 rtl/bus_xfer_ctrl_if.sv | 26 ++
 rtl/bus_xfer_ctrl.sv | 108 ++++++++++
 tb/tb_bus_xfer_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_xfer_ctrl_if.sv
// rtl/bus_xfer_ctrl_if.sv - request/strobe/status bundle for the bus transfer initiator
interface bus_xfer_ctrl_if #(
  parameter int NSEL = 8,
  parameter int SELW = 3
);
  logic            req;
  logic [SELW-1:0] src;
  logic [SELW-1:0] dst;
  logic [3:0]      bus;
  logic [NSEL-1:0] rs;
  logic [NSEL-1:0] ws;
  logic            busy;
  logic            done;
  logic            err;
  logic [3:0]      xdata;

  modport master (
    input  req, src, dst, bus,
    output rs, ws, busy, done, err, xdata
  );

  modport slave (
    output req, src, dst, bus,
    input  rs, ws, busy, done, err, xdata
  );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// rtl/bus_xfer_ctrl.sv - initiator sequencing read-select/write-select strobes on the 4-bit bus
module bus_xfer_ctrl #(
  parameter int NSEL  = 8,
  parameter int SELW  = 3,
  parameter int SETUP = 1
) (
  input  logic             clk,
  input  logic             rst,
  bus_xfer_ctrl_if.master  xif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam int CW = 2;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [SELW-1:0] dst_l;
  logic [NSEL-1:0] rs_q;
  logic [NSEL-1:0] ws_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;
  logic [3:0]      xdata_q;
  logic            src_ok;
  logic            dst_ok;
  logic            req_ok;

  function automatic logic [NSEL-1:0] onehot(input logic [SELW-1:0] idx);
    logic [NSEL-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Range checks only matter when the index width can name absent participants.
  if ((1 << SELW) > NSEL) begin : g_range
    assign src_ok = int'(xif.src) < NSEL;
    assign dst_ok = int'(xif.dst) < NSEL;
  end else begin : g_full
    assign src_ok = 1'b1;
    assign dst_ok = 1'b1;
  end

  assign req_ok = src_ok && dst_ok && (xif.src != xif.dst);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      dst_l   <= '0;
      rs_q    <= '0;
      ws_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      xdata_q <= 4'd0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xif.req) begin
            if (req_ok) begin
              dst_l  <= xif.dst;
              cnt    <= CW'(SETUP - 1);
              rs_q   <= onehot(xif.src);
              busy_q <= 1'b1;
              state  <= ST_DRIVE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          // rs alone for SETUP cycles so the source has settled before ws rises
          if (cnt == '0) begin
            ws_q  <= onehot(dst_l);
            state <= ST_WRITE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WRITE: begin
          xdata_q <= xif.bus;
          rs_q    <= '0;
          ws_q    <= '0;
          done_q  <= 1'b1;
          state   <= ST_DONE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign xif.rs    = rs_q;
  assign xif.ws    = ws_q;
  assign xif.busy  = busy_q;
  assign xif.done  = done_q;
  assign xif.err   = err_q;
  assign xif.xdata = xdata_q;

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// tb/tb_bus_xfer_ctrl.sv - directed self-checking bench for bus_xfer_ctrl (SETUP=1 and SETUP=3)
module tb_bus_xfer_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bus_xfer_ctrl_if #(.NSEL(8), .SELW(3)) if1 ();
  bus_xfer_ctrl_if #(.NSEL(8), .SELW(3)) if3 ();

  bus_xfer_ctrl #(.NSEL(8), .SELW(3), .SETUP(1)) dut1 (.clk(clk), .rst(rst), .xif(if1));
  bus_xfer_ctrl #(.NSEL(8), .SELW(3), .SETUP(3)) dut3 (.clk(clk), .rst(rst), .xif(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (if1.rs !== 8'h00 || if1.ws !== 8'h00 || if1.busy !== 1'b0 || if1.done !== 1'b0 ||
        if1.err !== 1'b0 || if1.xdata !== 4'h0) begin
      errors++;
      $display("FAIL reset_s1: rs=%b ws=%b busy=%b done=%b err=%b xdata=%h expected all zero",
               if1.rs, if1.ws, if1.busy, if1.done, if1.err, if1.xdata);
    end
    checks++;
    if (if3.rs !== 8'h00 || if3.ws !== 8'h00 || if3.busy !== 1'b0 || if3.done !== 1'b0 ||
        if3.err !== 1'b0 || if3.xdata !== 4'h0) begin
      errors++;
      $display("FAIL reset_s3: rs=%b ws=%b busy=%b done=%b err=%b xdata=%h expected all zero",
               if3.rs, if3.ws, if3.busy, if3.done, if3.err, if3.xdata);
    end
  endtask

  task automatic test_basic();
    if1.req = 1'b1; if1.src = 3'd5; if1.dst = 3'd3; if1.bus = 4'b1001;
    tick();
    if1.req = 1'b0;
    checks++;
    if (if1.rs !== 8'b0010_0000 || if1.ws !== 8'h00 || if1.busy !== 1'b1 || if1.done !== 1'b0) begin
      errors++;
      $display("FAIL basic_drive: rs=%b ws=%b busy=%b done=%b expected 00100000 00000000 1 0",
               if1.rs, if1.ws, if1.busy, if1.done);
    end
    tick();
    checks++;
    if (if1.rs !== 8'b0010_0000 || if1.ws !== 8'b0000_1000 || if1.busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_write: rs=%b ws=%b busy=%b expected 00100000 00001000 1",
               if1.rs, if1.ws, if1.busy);
    end
    tick();
    checks++;
    if (if1.rs !== 8'h00 || if1.ws !== 8'h00 || if1.busy !== 1'b1 || if1.done !== 1'b1 ||
        if1.err !== 1'b0 || if1.xdata !== 4'b1001) begin
      errors++;
      $display("FAIL basic_done: rs=%b ws=%b busy=%b done=%b err=%b xdata=%b expected 0 0 1 1 0 1001",
               if1.rs, if1.ws, if1.busy, if1.done, if1.err, if1.xdata);
    end
    tick();
    checks++;
    if (if1.busy !== 1'b0 || if1.done !== 1'b0 || if1.rs !== 8'h00) begin
      errors++;
      $display("FAIL basic_idle: busy=%b done=%b rs=%b expected 0 0 0", if1.busy, if1.done, if1.rs);
    end
  endtask

  task automatic test_err();
    if1.req = 1'b1; if1.src = 3'd2; if1.dst = 3'd2; if1.bus = 4'b0111;
    tick();
    if1.req = 1'b0;
    checks++;
    if (if1.err !== 1'b1 || if1.done !== 1'b0 || if1.rs !== 8'h00 || if1.ws !== 8'h00 ||
        if1.busy !== 1'b0 || if1.xdata !== 4'b1001) begin
      errors++;
      $display("FAIL err_pulse: err=%b done=%b rs=%b ws=%b busy=%b xdata=%b expected 1 0 0 0 0 1001",
               if1.err, if1.done, if1.rs, if1.ws, if1.busy, if1.xdata);
    end
    tick();
    checks++;
    if (if1.err !== 1'b0 || if1.busy !== 1'b0 || if1.xdata !== 4'b1001) begin
      errors++;
      $display("FAIL err_single: err=%b busy=%b xdata=%b expected 0 0 1001", if1.err, if1.busy, if1.xdata);
    end
  endtask

  task automatic test_ignore_inputs();
    if1.req = 1'b1; if1.src = 3'd1; if1.dst = 3'd6; if1.bus = 4'b0101;
    tick();
    if1.src = 3'd7; if1.dst = 3'd0;
    tick();
    checks++;
    if (if1.rs !== 8'b0000_0010 || if1.ws !== 8'b0100_0000) begin
      errors++;
      $display("FAIL ignore_write: rs=%b ws=%b expected 00000010 01000000", if1.rs, if1.ws);
    end
    if1.req = 1'b0;
    tick();
    checks++;
    if (if1.done !== 1'b1 || if1.xdata !== 4'b0101) begin
      errors++;
      $display("FAIL ignore_done: done=%b xdata=%b expected 1 0101", if1.done, if1.xdata);
    end
    tick();
    tick();
    checks++;
    if (if1.busy !== 1'b0 || if1.rs !== 8'h00) begin
      errors++;
      $display("FAIL ignore_no_extra: busy=%b rs=%b expected 0 0", if1.busy, if1.rs);
    end
  endtask

  task automatic test_async_reset();
    if1.req = 1'b1; if1.src = 3'd4; if1.dst = 3'd2; if1.bus = 4'b1100;
    tick();
    if1.req = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (if1.rs !== 8'h00 || if1.ws !== 8'h00 || if1.busy !== 1'b0 || if1.done !== 1'b0 ||
        if1.xdata !== 4'h0) begin
      errors++;
      $display("FAIL async_rst: rs=%b ws=%b busy=%b done=%b xdata=%h expected all zero",
               if1.rs, if1.ws, if1.busy, if1.done, if1.xdata);
    end
    tick();
    checks++;
    if (if1.done !== 1'b0 || if1.busy !== 1'b0) begin
      errors++;
      $display("FAIL async_no_done: done=%b busy=%b expected 0 0", if1.done, if1.busy);
    end
    rst = 1'b1;
    tick();
    if1.req = 1'b1; if1.src = 3'd0; if1.dst = 3'd7; if1.bus = 4'b0011;
    tick();
    if1.req = 1'b0;
    checks++;
    if (if1.rs !== 8'b0000_0001 || if1.ws !== 8'h00) begin
      errors++;
      $display("FAIL post_rst_drive: rs=%b ws=%b expected 00000001 00000000", if1.rs, if1.ws);
    end
    tick();
    checks++;
    if (if1.ws !== 8'b1000_0000) begin
      errors++;
      $display("FAIL post_rst_write: ws=%b expected 10000000", if1.ws);
    end
    tick();
    checks++;
    if (if1.done !== 1'b1 || if1.xdata !== 4'b0011) begin
      errors++;
      $display("FAIL post_rst_done: done=%b xdata=%b expected 1 0011", if1.done, if1.xdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    if1.req = 1'b1; if1.src = 3'd0; if1.dst = 3'd1; if1.bus = 4'b0110;
    tick();
    checks++;
    if (if1.rs !== 8'b0000_0001) begin
      errors++;
      $display("FAIL b2b_drive1: rs=%b expected 00000001", if1.rs);
    end
    if1.src = 3'd1; if1.dst = 3'd4;
    tick();
    checks++;
    if (if1.rs !== 8'b0000_0001 || if1.ws !== 8'b0000_0010) begin
      errors++;
      $display("FAIL b2b_write1: rs=%b ws=%b expected 00000001 00000010", if1.rs, if1.ws);
    end
    tick();
    checks++;
    if (if1.done !== 1'b1 || if1.xdata !== 4'b0110) begin
      errors++;
      $display("FAIL b2b_done1: done=%b xdata=%b expected 1 0110", if1.done, if1.xdata);
    end
    if1.bus = 4'b1111;
    tick();
    checks++;
    if (if1.busy !== 1'b0 || if1.rs !== 8'h00 || if1.done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: busy=%b rs=%b done=%b expected 0 0 0", if1.busy, if1.rs, if1.done);
    end
    tick();
    checks++;
    if (if1.busy !== 1'b1 || if1.rs !== 8'b0000_0010 || if1.ws !== 8'h00) begin
      errors++;
      $display("FAIL b2b_drive2: busy=%b rs=%b ws=%b expected 1 00000010 0", if1.busy, if1.rs, if1.ws);
    end
    tick();
    if1.req = 1'b0;
    checks++;
    if (if1.ws !== 8'b0001_0000) begin
      errors++;
      $display("FAIL b2b_write2: ws=%b expected 00010000", if1.ws);
    end
    tick();
    checks++;
    if (if1.done !== 1'b1 || if1.xdata !== 4'b1111) begin
      errors++;
      $display("FAIL b2b_done2: done=%b xdata=%b expected 1 1111", if1.done, if1.xdata);
    end
    tick();
  endtask

  task automatic test_setup3();
    logic [7:0] exp_rs [6];
    logic [7:0] exp_ws [6];
    logic       exp_busy [6];
    logic       exp_done [6];
    exp_rs   = '{8'h40, 8'h40, 8'h40, 8'h40, 8'h00, 8'h00};
    exp_ws   = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00};
    exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_done = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    if3.req = 1'b1; if3.src = 3'd6; if3.dst = 3'd1; if3.bus = 4'b1010;
    for (int i = 0; i < 6; i++) begin
      tick();
      if3.req = 1'b0;
      checks++;
      if (if3.rs !== exp_rs[i] || if3.ws !== exp_ws[i] || if3.busy !== exp_busy[i] ||
          if3.done !== exp_done[i]) begin
        errors++;
        $display("FAIL setup3_cycle%0d: rs=%b ws=%b busy=%b done=%b expected %b %b %b %b",
                 i, if3.rs, if3.ws, if3.busy, if3.done, exp_rs[i], exp_ws[i], exp_busy[i], exp_done[i]);
      end
    end
    checks++;
    if (if3.xdata !== 4'b1010) begin
      errors++;
      $display("FAIL setup3_xdata: xdata=%b expected 1010", if3.xdata);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    if1.req = 1'b0; if1.src = '0; if1.dst = '0; if1.bus = '0;
    if3.req = 1'b0; if3.src = '0; if3.dst = '0; if3.bus = '0;
    tick();
    tick();
    test_reset();
    rst = 1'b1;
    tick();
    test_basic();
    test_err();
    test_ignore_inputs();
    test_async_reset();
    test_back_to_back();
    test_setup3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
